// File: rtl/tinyriscv_test_monitor_pkg.sv
// Shared widths, monitor FSM encoding and default ISA-test handshake register indices.
package tinyriscv_defines;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam int TEST_DONE_REG = 26;
  localparam int TEST_PASS_REG = 27;
  localparam int TEST_NUM_REG  = 3;

  typedef enum logic [1:0] {
    MON_RESET  = 2'd0,
    MON_RUN    = 2'd1,
    MON_SETTLE = 2'd2,
    MON_DONE   = 2'd3
  } mon_state_t;

  function automatic logic [RegBus-1:0] sat_inc(input logic [RegBus-1:0] v);
    return (v == {RegBus{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tinyriscv_test_monitor_reg_snoop.sv
// One shadow of a regfile register, loaded on a matching write port hit unless frozen.
module mon_reg_snoop
  import tinyriscv_defines::*;
#(
  parameter int IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic [RegBus-1:0]     wdata,
  input  logic                  freeze,
  output logic [RegBus-1:0]     q_next
);

  localparam logic [RegAddrBus-1:0] ADDR = RegAddrBus'(IDX);

  logic [RegBus-1:0] q;

  // x0 is hardwired to zero in the core, so writes to it never reach a shadow
  assign q_next = (we && !freeze && (waddr == ADDR) && (waddr != '0)) ? wdata : q;

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= q_next;
  end

endmodule

// File: rtl/tinyriscv_test_monitor.sv
// Snoops the regfile write port and turns the x26/x27/x3 ISA-test handshake into flat verdicts.
module tinyriscv_test_monitor
  import tinyriscv_defines::*;
#(
  parameter int DONE_REG       = TEST_DONE_REG,
  parameter int PASS_REG       = TEST_PASS_REG,
  parameter int NUM_REG        = TEST_NUM_REG,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [RegAddrBus-1:0] waddr_i,
  input  logic [RegBus-1:0]     wdata_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [RegBus-1:0]     testnum_o,
  output logic [RegBus-1:0]     cycle_cnt_o
);

  localparam logic [RegAddrBus-1:0] DONE_ADDR   = RegAddrBus'(DONE_REG);
  localparam logic [RegBus-1:0]     SETTLE_LOAD = RegBus'(SETTLE_CYCLES - 1);
  localparam logic [RegBus-1:0]     TO_LAST     = RegBus'(TIMEOUT_CYCLES - 1);

  mon_state_t        state;
  logic [RegBus-1:0] cycle_cnt;
  logic [RegBus-1:0] cycle_inc;
  logic [RegBus-1:0] settle_cnt;
  logic [RegBus-1:0] done_next;
  logic [RegBus-1:0] pass_next;
  logic [RegBus-1:0] num_next;
  logic              freeze;
  logic              done_trig;
  logic              pass_now;

  assign freeze    = (state == MON_DONE);
  assign cycle_inc = sat_inc(cycle_cnt);
  assign pass_now  = (pass_next == 32'h1);
  assign done_trig = we_i && (waddr_i == DONE_ADDR) && (DONE_ADDR != '0)
                     && (done_next == 32'h1);

  mon_reg_snoop #(.IDX(DONE_REG)) u_done (
    .clk(clk), .rst_n(rst_n), .we(we_i), .waddr(waddr_i), .wdata(wdata_i),
    .freeze(freeze), .q_next(done_next)
  );

  mon_reg_snoop #(.IDX(PASS_REG)) u_pass (
    .clk(clk), .rst_n(rst_n), .we(we_i), .waddr(waddr_i), .wdata(wdata_i),
    .freeze(freeze), .q_next(pass_next)
  );

  mon_reg_snoop #(.IDX(NUM_REG)) u_num (
    .clk(clk), .rst_n(rst_n), .we(we_i), .waddr(waddr_i), .wdata(wdata_i),
    .freeze(freeze), .q_next(num_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= MON_RESET;
      cycle_cnt   <= '0;
      settle_cnt  <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      testnum_o   <= '0;
      cycle_cnt_o <= '0;
    end else begin
      case (state)
        MON_RESET: state <= MON_RUN;
        MON_RUN: begin
          cycle_cnt   <= cycle_inc;
          cycle_cnt_o <= cycle_inc;
          testnum_o   <= num_next;
          // a done write in the timeout cycle takes priority over the timeout
          if (done_trig) begin
            state      <= MON_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end else if (cycle_cnt == TO_LAST) begin
            state     <= MON_DONE;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            pass_o    <= 1'b0;
          end
        end
        MON_SETTLE: begin
          cycle_cnt   <= cycle_inc;
          cycle_cnt_o <= cycle_inc;
          testnum_o   <= num_next;
          settle_cnt  <= settle_cnt - 1'b1;
          if (settle_cnt == '0) begin
            state  <= MON_DONE;
            done_o <= 1'b1;
            pass_o <= pass_now;
            fail_o <= !pass_now;
          end
        end
        MON_DONE: state <= MON_DONE;
        default:  state <= MON_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyriscv_test_monitor.sv
// Directed bench for the ISA-test monitor with TIMEOUT_CYCLES=50, SETTLE_CYCLES=5.
module tb_tinyriscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] testnum_o, cycle_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  tinyriscv_test_monitor #(
    .DONE_REG(26), .PASS_REG(27), .NUM_REG(3),
    .SETTLE_CYCLES(5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .testnum_o(testnum_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic en = 1'b1);
    we_i = en; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0; waddr_i = '0; wdata_i = '0;
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass_o}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail_o}, 32'd0);
    chk({tag, "_tmo"},  {31'd0, timeout_o}, 32'd0);
    chk({tag, "_num"},  testnum_o, 32'd0);
    chk({tag, "_cnt"},  cycle_cnt_o, 32'd0);
  endtask

  // After this returns the FSM has just entered RUN; the next edge is run index 0.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; we_i = 1'b0;
    tick(2);
    outs_zero(tag);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // pass path: x3=7, x27=1, x26=1 at run index 40
    do_reset("rst1");
    wr(5'd3, 32'd7);
    wr(5'd27, 32'd1);
    tick(38);
    wr(5'd26, 32'd1);
    tick(4);
    chk("t1_done_early", {31'd0, done_o}, 32'd0);
    tick();
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_pass", {31'd0, pass_o}, 32'd1);
    chk("t1_fail", {31'd0, fail_o}, 32'd0);
    chk("t1_tmo",  {31'd0, timeout_o}, 32'd0);
    chk("t1_num",  testnum_o, 32'd7);
    chk("t1_cnt",  cycle_cnt_o, 32'd46);
    tick(20);
    chk("t1_sticky", {31'd0, done_o}, 32'd1);
    chk("t1_cnt_frozen", cycle_cnt_o, 32'd46);

    // fail path, then post-verdict x3 write must not move testnum
    do_reset("rst2");
    wr(5'd27, 32'd0);
    wr(5'd3, 32'd12);
    wr(5'd26, 32'd1);
    tick(5);
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_fail", {31'd0, fail_o}, 32'd1);
    chk("t2_pass", {31'd0, pass_o}, 32'd0);
    chk("t2_num",  testnum_o, 32'd12);
    wr(5'd3, 32'd99);
    tick();
    chk("t2_num_frozen", testnum_o, 32'd12);

    // late x27=1 on the 3rd SETTLE cycle still counts
    do_reset("rst3");
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    tick(2);
    wr(5'd27, 32'd1);
    tick(2);
    chk("t3a_done", {31'd0, done_o}, 32'd1);
    chk("t3a_pass", {31'd0, pass_o}, 32'd1);
    chk("t3a_fail", {31'd0, fail_o}, 32'd0);

    // x27=1 after DONE is ignored
    do_reset("rst3b");
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    tick(5);
    chk("t3b_done", {31'd0, done_o}, 32'd1);
    wr(5'd27, 32'd1);
    tick();
    chk("t3b_pass", {31'd0, pass_o}, 32'd0);
    chk("t3b_fail", {31'd0, fail_o}, 32'd1);

    // timeout with no done write
    do_reset("rst4");
    tick(49);
    chk("t4a_done_early", {31'd0, done_o}, 32'd0);
    tick();
    chk("t4a_done", {31'd0, done_o}, 32'd1);
    chk("t4a_tmo",  {31'd0, timeout_o}, 32'd1);
    chk("t4a_fail", {31'd0, fail_o}, 32'd1);
    chk("t4a_pass", {31'd0, pass_o}, 32'd0);
    chk("t4a_cnt",  cycle_cnt_o, 32'd50);

    // done write in the timeout cycle wins
    do_reset("rst4b");
    tick(49);
    wr(5'd26, 32'd1);
    chk("t4b_done_early", {31'd0, done_o}, 32'd0);
    chk("t4b_tmo_early",  {31'd0, timeout_o}, 32'd0);
    tick(5);
    chk("t4b_done", {31'd0, done_o}, 32'd1);
    chk("t4b_tmo",  {31'd0, timeout_o}, 32'd0);
    chk("t4b_fail", {31'd0, fail_o}, 32'd1);
    chk("t4b_cnt",  cycle_cnt_o, 32'd55);

    // non-trigger writes
    do_reset("rst5");
    wr(5'd3, 32'd5);
    wr(5'd26, 32'd2);
    wr(5'd0, 32'd1);
    wr(5'd26, 32'd1, 1'b0);
    wr(5'd3, 32'd77, 1'b0);
    tick(8);
    chk("t5_no_trig", {31'd0, done_o}, 32'd0);
    chk("t5_num", testnum_o, 32'd5);
    wr(5'd26, 32'd1);
    tick(5);
    chk("t5_trig_ok", {31'd0, done_o}, 32'd1);

    // reset mid-SETTLE, then a clean run
    do_reset("rst6");
    wr(5'd27, 32'd1);
    wr(5'd3, 32'd4);
    wr(5'd26, 32'd1);
    tick(2);
    rst_n = 1'b0;
    tick();
    outs_zero("t6_mid");
    rst_n = 1'b1;
    tick();
    wr(5'd26, 32'd1);
    tick(5);
    chk("t6_done", {31'd0, done_o}, 32'd1);
    chk("t6_pass", {31'd0, pass_o}, 32'd0);
    chk("t6_num",  testnum_o, 32'd0);
    chk("t6_cnt",  cycle_cnt_o, 32'd6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
